// File: rtl/reg_writeback_queue_if.sv
// Bundle of the two producer handshakes, the drain hold and the register-file write port.
// Pure wiring, no latency of its own.
// Readies travel slave->master; the write port has no backpressure.
interface reg_writeback_queue_if #(
  parameter int DATA_W = 8
);
  logic              mem_valid;
  logic              mem_ready;
  logic [1:0]        mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [1:0]        alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              wb_hold;
  logic              rf_write_en;
  logic [1:0]        rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;

  // Producers and the hold source drive the request side.
  modport master (
    output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, wb_hold,
    input  mem_ready, alu_ready, rf_write_en, rf_write_addr, rf_write_data
  );

  // The queue answers with readies and drives the write port.
  modport slave (
    input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, wb_hold,
    output mem_ready, alu_ready, rf_write_en, rf_write_addr, rf_write_data
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO merging load and ALU results onto one register-file write port, with a per-register pending scoreboard; optional WB_FORWARD_EN adds a youngest-match forward lookup.
// Latency: result accepted at edge N is on rf_write_* in cycle N+1 (empty FIFO, no hold); pending is registered, valid the cycle after accept.
// Backpressure: readies reflect free slots including this cycle's pop; load path has fixed priority, ALU needs a second slot when a load is offered.
module reg_writeback_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  reg_writeback_queue_if.slave     wb,
  output logic [3:0]               pending,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_FORWARD_EN
  ,
  input  logic [1:0]               fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]        addr_q [DEPTH];
  logic [1:0]        addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     pcnt_q [4];
  logic [CW-1:0]     pcnt_d [4];
  logic [3:0]        pending_q, pending_d;

  logic              pop;
  logic              mem_acc;
  logic              alu_acc;
  logic [CW:0]       free;
  logic [AW-1:0]     alu_slot;
  logic [1:0]        head_addr;

  // Handshake decisions and the combinational write port taken straight from the head.
  always_comb begin
    pop        = !reset && (count_q != '0) && !wb.wb_hold;
    free       = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
    wb.mem_ready = !reset && (free != '0);
    wb.alu_ready = !reset && (free >= (wb.mem_valid ? (CW+1)'(2) : (CW+1)'(1)));
    mem_acc    = wb.mem_valid && wb.mem_ready;
    alu_acc    = wb.alu_valid && wb.alu_ready;
    head_addr  = addr_q[rd_ptr_q];
    wb.rf_write_en   = pop;
    wb.rf_write_addr = head_addr;
    wb.rf_write_data = data_q[rd_ptr_q];
  end

  // Next-state: load enqueued ahead of the ALU result since it is the older instruction.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    alu_slot = wr_ptr_q + AW'(mem_acc);
    if (mem_acc) begin
      addr_d[wr_ptr_q] = wb.mem_addr;
      data_d[wr_ptr_q] = wb.mem_data;
    end
    if (alu_acc) begin
      addr_d[alu_slot] = wb.alu_addr;
      data_d[alu_slot] = wb.alu_data;
    end
    wr_ptr_d = wr_ptr_q + AW'(mem_acc) + AW'(alu_acc);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(pop);
    for (int r = 0; r < 4; r++) begin
      pcnt_d[r] = pcnt_q[r]
                + CW'(mem_acc && (wb.mem_addr == 2'(r)))
                + CW'(alu_acc && (wb.alu_addr == 2'(r)))
                - CW'(pop && (head_addr == 2'(r)));
      pending_d[r] = (pcnt_d[r] != '0);
    end
  end

  // State registers; reset drops every queued entry without writing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      for (int r = 0; r < 4; r++) begin
        pcnt_q[r] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      assert (count_d <= CW'(DEPTH))
        else $error("writeback queue overflow: count_d=%0d", count_d);
      addr_q    <= addr_d;
      data_q    <= data_d;
      pcnt_q    <= pcnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
  assign count   = count_q;

`ifdef WB_FORWARD_EN
  logic [AW-1:0] fwd_idx;

  // Walk oldest to youngest so the last match left standing is the youngest queued entry.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + AW'(i);
      if ((CW'(i) < count_q) && (addr_q[fwd_idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for the writeback queue: a queue-based model is checked every cycle, plus literal pins.
// Inputs change 1 time unit after posedge; all sampling happens on negedge.
// The model advances on posedge using the same free-slot rules the producers see.
module tb_reg_writeback_queue;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [1:0]        a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic             clk;
  logic             reset;
  logic [3:0]       pending;
  logic [2:0]       count;
`ifdef WB_FORWARD_EN
  logic [1:0]        fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;
  ent_t mq[$];

  reg_writeback_queue_if #(.DATA_W(DATA_W)) wbif ();

  reg_writeback_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wb      (wbif.slave),
    .pending (pending),
    .count   (count)
`ifdef WB_FORWARD_EN
    ,
    .fwd_addr(fwd_addr),
    .fwd_hit (fwd_hit),
    .fwd_data(fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: occupancy is the queue length; a pop frees a slot the same cycle.
  always @(posedge clk) begin : model
    bit pp, ma, aa;
    int fr;
    if (reset) begin
      mq.delete();
    end else begin
      pp = (mq.size() != 0) && !wbif.wb_hold;
      fr = DEPTH - mq.size() + int'(pp);
      ma = wbif.mem_valid && (fr >= 1);
      aa = wbif.alu_valid && (fr >= (wbif.mem_valid ? 2 : 1));
      if (pp) void'(mq.pop_front());
      if (ma) mq.push_back('{a: wbif.mem_addr, d: wbif.mem_data});
      if (aa) mq.push_back('{a: wbif.alu_addr, d: wbif.alu_data});
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : cmp
    int sz, fr;
    bit en;
    logic [3:0] pe;
    sz = mq.size();
    en = !reset && (sz != 0) && !wbif.wb_hold;
    fr = DEPTH - sz + int'(en);
    pe = 4'b0000;
    foreach (mq[i]) pe[mq[i].a] = 1'b1;
    check("cmp_count", count, sz);
    check("cmp_en", wbif.rf_write_en, en);
    if (en) begin
      check("cmp_addr", wbif.rf_write_addr, mq[0].a);
      check("cmp_data", wbif.rf_write_data, mq[0].d);
    end
    check("cmp_mem_ready", wbif.mem_ready, !reset && (fr >= 1));
    check("cmp_alu_ready", wbif.alu_ready, !reset && (fr >= (wbif.mem_valid ? 2 : 1)));
    check("cmp_pending", pending, pe);
`ifdef WB_FORWARD_EN
    begin
      bit h;
      logic [DATA_W-1:0] fd;
      h  = 1'b0;
      fd = '0;
      foreach (mq[i]) if (mq[i].a == fwd_addr) begin h = 1'b1; fd = mq[i].d; end
      check("cmp_fwd_hit", fwd_hit, h);
      if (h) check("cmp_fwd_data", fwd_data, fd);
    end
`endif
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    reset          = 1'b1;
    wbif.mem_valid = 1'b0; wbif.mem_addr = '0; wbif.mem_data = '0;
    wbif.alu_valid = 1'b0; wbif.alu_addr = '0; wbif.alu_data = '0;
    wbif.wb_hold   = 1'b0;
`ifdef WB_FORWARD_EN
    fwd_addr = 2'd0;
`endif
    step(); step();

    // Reset: offers are refused, nothing queued, nothing written.
    wbif.mem_valid = 1'b1; wbif.alu_valid = 1'b1;
    @(negedge clk);
    check("rst_mem_ready", wbif.mem_ready, 0);
    check("rst_alu_ready", wbif.alu_ready, 0);
    check("rst_count", count, 0);
    check("rst_en", wbif.rf_write_en, 0);
    check("rst_pending", pending, 0);
    step();
    reset = 1'b0; wbif.mem_valid = 1'b0; wbif.alu_valid = 1'b0;
    step();

    // 1: single load r2=0x5A, one-cycle latency.
    wbif.mem_valid = 1'b1; wbif.mem_addr = 2'd2; wbif.mem_data = 8'h5A;
    @(negedge clk);
    check("t1_mem_ready", wbif.mem_ready, 1);
    step();
    wbif.mem_valid = 1'b0;
    @(negedge clk);
    check("t1_en", wbif.rf_write_en, 1);
    check("t1_addr", wbif.rf_write_addr, 2);
    check("t1_data", wbif.rf_write_data, 8'h5A);
    check("t1_pending", pending, 4'b0100);
    check("t1_count", count, 1);
    step();
    @(negedge clk);
    check("t1_pending_after", pending, 0);
    check("t1_count_after", count, 0);
    step();

    // 2: load and ALU to r1 together, load lands first.
    wbif.mem_valid = 1'b1; wbif.mem_addr = 2'd1; wbif.mem_data = 8'h11;
    wbif.alu_valid = 1'b1; wbif.alu_addr = 2'd1; wbif.alu_data = 8'h22;
    @(negedge clk);
    check("t2_mem_ready", wbif.mem_ready, 1);
    check("t2_alu_ready", wbif.alu_ready, 1);
    step();
    wbif.mem_valid = 1'b0; wbif.alu_valid = 1'b0;
    @(negedge clk);
    check("t2_first", wbif.rf_write_data, 8'h11);
    check("t2_count", count, 2);
    check("t2_pending", pending, 4'b0010);
    step();
    @(negedge clk);
    check("t2_second", wbif.rf_write_data, 8'h22);
    step();
    @(negedge clk);
    check("t2_pending_after", pending, 0);
    step();

    // 3: fill under hold with ALU r0..r3, then offers are refused.
    wbif.wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wbif.alu_valid = 1'b1; wbif.alu_addr = 2'(i); wbif.alu_data = 8'hA0 + 8'(i);
      @(negedge clk);
      step();
    end
    wbif.alu_addr = 2'd0; wbif.alu_data = 8'h99;
    wbif.mem_valid = 1'b1; wbif.mem_addr = 2'd1; wbif.mem_data = 8'h77;
    @(negedge clk);
    check("t3_count", count, 4);
    check("t3_en", wbif.rf_write_en, 0);
    check("t3_pending", pending, 4'b1111);
    check("t3_alu_ready", wbif.alu_ready, 0);
    check("t3_mem_ready", wbif.mem_ready, 0);
    step();
    @(negedge clk);
    check("t3_count_kept", count, 4);
    step();

    // 4: full, hold released: load takes the popped slot, ALU waits.
    wbif.wb_hold = 1'b0;
    wbif.alu_addr = 2'd2; wbif.alu_data = 8'h88;
    @(negedge clk);
    check("t4_mem_ready", wbif.mem_ready, 1);
    check("t4_alu_ready", wbif.alu_ready, 0);
    check("t4_en", wbif.rf_write_en, 1);
    check("t4_addr", wbif.rf_write_addr, 0);
    check("t4_data", wbif.rf_write_data, 8'hA0);
    step();
    wbif.mem_valid = 1'b0; wbif.alu_valid = 1'b0; wbif.wb_hold = 1'b1;
    @(negedge clk);
    check("t4_count", count, 4);
    check("t4_pending", pending, 4'b1110);
    step();

    // 5: drain one, then reset with three queued.
    wbif.wb_hold = 1'b0;
    @(negedge clk);
    check("t5_data", wbif.rf_write_data, 8'hA1);
    step();
    wbif.wb_hold = 1'b1;
    @(negedge clk);
    check("t5_count", count, 3);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; wbif.wb_hold = 1'b0;
    @(negedge clk);
    check("t5_count_rst", count, 0);
    check("t5_pending_rst", pending, 0);
    check("t5_en_rst", wbif.rf_write_en, 0);
    step();
    @(negedge clk);
    check("t5_en_later", wbif.rf_write_en, 0);
    step();

`ifdef WB_FORWARD_EN
    // 6: youngest match wins; entries accepted this cycle are invisible.
    wbif.wb_hold = 1'b1; fwd_addr = 2'd3;
    wbif.mem_valid = 1'b1; wbif.mem_addr = 2'd3; wbif.mem_data = 8'h10;
    @(negedge clk);
    check("t6_not_visible", fwd_hit, 0);
    step();
    wbif.mem_data = 8'h20;
    @(negedge clk);
    check("t6_hit_one", fwd_hit, 1);
    check("t6_data_one", fwd_data, 8'h10);
    step();
    wbif.mem_valid = 1'b0;
    @(negedge clk);
    check("t6_hit", fwd_hit, 1);
    check("t6_data", fwd_data, 8'h20);
    step();
    fwd_addr = 2'd0;
    @(negedge clk);
    check("t6_miss", fwd_hit, 0);
    step();
    wbif.wb_hold = 1'b0;
`endif

    repeat (6) step();
    @(negedge clk);
    check("end_count", count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
